// File: rtl/serial_rx_pkg.sv
// serial_rx_pkg: shared types and defaults for the serial frame receiver.
//   state_t        - receiver FSM state encoding
//   SYNC_W_DEF etc - default sync/payload geometry
//   parity_bad()   - parity verdict over payload reduction plus parity bit
package serial_rx_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int unsigned SYNC_W_DEF = 4;
    localparam logic [3:0]  SYNC_DEF   = 4'b1011;
    localparam int unsigned DATA_W_DEF = 8;

    // payload_xor is the XOR reduction of the payload; a frame is bad when the
    // total parity of payload plus parity bit differs from the selected sense.
    function automatic logic parity_bad(input logic payload_xor, input logic par_bit,
                                        input logic odd_par);
        return (payload_xor ^ par_bit) != odd_par;
    endfunction

endpackage

// File: rtl/serial_frame_rx_sync_window.sv
// sync_window: SYNC_W-bit history shift register with a combinational match.
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-low reset (clears history)
//   en     - shift sin into the history this edge
//   clr    - synchronous clear of the history (beats en)
//   bit_in - serial bit
//   match  - high when {history[W-2:0], bit_in} equals PAT
module sync_window #(
    parameter int unsigned W   = 4,
    parameter logic [W-1:0] PAT = 4'b1011
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic bit_in,
    output logic match
);

    logic [W-1:0] hist_q;
    logic [W-1:0] hist_next;

    // Match looks at the window including the bit being sampled now, so the
    // sync is recognised on the same edge that delivers its last bit.
    assign hist_next = {hist_q[W-2:0], bit_in};
    assign match     = (hist_next == PAT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            hist_q <= '0;
        end else if (clr) begin
            hist_q <= '0;
        end else if (en) begin
            hist_q <= hist_next;
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: hunts a serial stream for a sync pattern, deserialises a
// DATA_W-bit payload MSB-first and checks a trailing parity bit.
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-low reset
//   sin        - serial data in
//   sin_en     - bit enable; sin is sampled only when high
//   dout       - last received payload (held between frames)
//   dout_valid - one-cycle strobe when dout/parity_err update
//   parity_err - parity verdict of the last frame (held)
//   sync_lock  - high while receiving payload or parity
//   frame_cnt  - count of good-parity frames, wrapping
module serial_frame_rx
    import serial_rx_pkg::*;
#(
    parameter int unsigned SYNC_W  = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC = SYNC_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter bit          ODD_PAR = 1'b0,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    input  logic              sin_en,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              parity_err,
    output logic              sync_lock,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int unsigned BW = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_t              state_q, state_d;
    logic [BW-1:0]       bit_cnt_q;
    logic [DATA_W-1:0]   shift_q;
    logic [DATA_W-1:0]   dout_q;
    logic                valid_q;
    logic                perr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                sync_match;
    logic                frame_bad;

    sync_window #(
        .W   (SYNC_W),
        .PAT (SYNC)
    ) u_sync_window (
        .clk    (clk),
        .rst    (rst),
        .en     (sin_en && (state_q == HUNT)),
        .clr    (sin_en && (state_q == PARITY)),
        .bit_in (sin),
        .match  (sync_match)
    );

    assign frame_bad = parity_bad(^shift_q, sin, ODD_PAR);

    always_comb begin
        state_d = state_q;
        case (state_q)
            HUNT:    if (sin_en && sync_match) state_d = DATA;
            DATA:    if (sin_en && (bit_cnt_q == LAST_BIT)) state_d = PARITY;
            PARITY:  if (sin_en) state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= HUNT;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= 1'b0;
            if (sin_en) begin
                case (state_q)
                    HUNT: begin
                        if (sync_match) bit_cnt_q <= '0;
                    end
                    DATA: begin
                        shift_q   <= {shift_q[DATA_W-2:0], sin};
                        bit_cnt_q <= bit_cnt_q + BW'(1);
                    end
                    PARITY: begin
                        dout_q  <= shift_q;
                        perr_q  <= frame_bad;
                        valid_q <= 1'b1;
                        if (!frame_bad) cnt_q <= cnt_q + CNT_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_cnt  = cnt_q;
    assign sync_lock  = (state_q != HUNT);

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: directed test-plan scenarios plus randomised frames and
// noise, compared every cycle against a bit-stream level reference model.
// A second instance with a 2-bit frame counter exercises counter wrap.
module tb_serial_frame_rx;

    localparam int SYNC_W  = 4;
    localparam logic [3:0] SYNC = 4'b1011;
    localparam int DATA_W  = 8;
    localparam bit ODD_PAR = 1'b0;
    localparam int CNT_W   = 8;
    localparam int CNT_W2  = 2;

    logic clk = 1'b0;
    logic rst, sin, sin_en;
    logic [DATA_W-1:0] dout, dout2;
    logic dout_valid, parity_err, sync_lock;
    logic dout_valid2, parity_err2, sync_lock2;
    logic [CNT_W-1:0]  frame_cnt;
    logic [CNT_W2-1:0] frame_cnt2;

    always #10 clk = ~clk;

    serial_frame_rx #(
        .SYNC_W (SYNC_W), .SYNC (SYNC), .DATA_W (DATA_W), .ODD_PAR (ODD_PAR), .CNT_W (CNT_W)
    ) u_dut (
        .clk (clk), .rst (rst), .sin (sin), .sin_en (sin_en),
        .dout (dout), .dout_valid (dout_valid), .parity_err (parity_err),
        .sync_lock (sync_lock), .frame_cnt (frame_cnt)
    );

    serial_frame_rx #(
        .SYNC_W (SYNC_W), .SYNC (SYNC), .DATA_W (DATA_W), .ODD_PAR (ODD_PAR), .CNT_W (CNT_W2)
    ) u_dut_wrap (
        .clk (clk), .rst (rst), .sin (sin), .sin_en (sin_en),
        .dout (dout2), .dout_valid (dout_valid2), .parity_err (parity_err2),
        .sync_lock (sync_lock2), .frame_cnt (frame_cnt2)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: works on the enabled bit stream, not on registers.
    int m_mode;   // 0 hunting, 1 collecting payload, 2 awaiting parity
    bit hq[$];    // the last SYNC_W stream bits seen while hunting
    int m_word, m_dcnt;
    int e_dout, e_perr, e_valid, e_cnt, e_cnt2;

    function automatic void model_reset();
        hq.delete();
        for (int i = 0; i < SYNC_W; i++) hq.push_back(1'b0);
        m_mode = 0; m_word = 0; m_dcnt = 0;
        e_dout = 0; e_perr = 0; e_valid = 0; e_cnt = 0; e_cnt2 = 0;
    endfunction

    function automatic void model_edge(input bit b, input bit en);
        int v;
        int ones;
        e_valid = 0;
        if (!en) return;
        if (m_mode == 0) begin
            void'(hq.pop_front());
            hq.push_back(b);
            v = 0;
            foreach (hq[i]) v = v * 2 + int'(hq[i]);
            if (v == int'(SYNC)) begin
                m_mode = 1; m_word = 0; m_dcnt = 0;
            end
        end else if (m_mode == 1) begin
            m_word = m_word * 2 + int'(b);
            m_dcnt++;
            if (m_dcnt == DATA_W) m_mode = 2;
        end else begin
            ones = $countones(m_word) + int'(b);
            e_perr = ((ones % 2) != int'(ODD_PAR)) ? 1 : 0;
            e_dout = m_word;
            e_valid = 1;
            if (e_perr == 0) begin
                e_cnt  = (e_cnt + 1) % (1 << CNT_W);
                e_cnt2 = (e_cnt2 + 1) % (1 << CNT_W2);
            end
            m_mode = 0;
            hq.delete();
            for (int i = 0; i < SYNC_W; i++) hq.push_back(1'b0);
        end
    endfunction

    task automatic compare_all();
        check("valid", 32'(dout_valid), 32'(e_valid));
        check("lock", 32'(sync_lock), 32'(m_mode != 0));
        check("dout", 32'(dout), 32'(e_dout));
        check("perr", 32'(parity_err), 32'(e_perr));
        check("cnt", 32'(frame_cnt), 32'(e_cnt));
        check("cnt_wrap", 32'(frame_cnt2), 32'(e_cnt2));
        check("valid_wrap", 32'(dout_valid2), 32'(e_valid));
    endtask

    task automatic step(input logic b, input logic en);
        sin = b; sin_en = en;
        @(posedge clk);
        model_edge(b, en);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b0; sin = 1'($urandom); sin_en = 1'($urandom);
        @(posedge clk);
        model_reset();
        #1;
        compare_all();
        rst = 1'b1;
    endtask

    // Send n bits of val MSB-first; optionally stall stall_len cycles before
    // bit index stall_at (counted from the first bit sent).
    task automatic send_bits(input int val, input int n, input int stall_at = -1,
                             input int stall_len = 0);
        for (int i = n - 1; i >= 0; i--) begin
            if ((n - 1 - i) == stall_at)
                for (int s = 0; s < stall_len; s++) step(1'($urandom), 1'b0);
            step(1'(val >> i), 1'b1);
        end
    endtask

    task automatic send_frame(input int data, input int par, input int stall_at = -1,
                              input int stall_len = 0);
        send_bits(int'(SYNC), SYNC_W);
        send_bits(data, DATA_W, stall_at, stall_len);
        send_bits(par, 1);
    endtask

    function automatic int good_par(input int data);
        return ($countones(data) % 2) ^ int'(ODD_PAR);
    endfunction

    initial begin
        int exp_wrap [5] = '{1, 2, 3, 0, 1};
        int d;
        rst = 1'b1; sin = 1'b0; sin_en = 1'b0;
        model_reset();
        do_reset();

        // Reset mid-frame discards the partial frame.
        send_bits(int'(SYNC), SYNC_W);
        send_bits(3'b101, 3);
        do_reset();
        check("midrst_lock", 32'(sync_lock), 32'd0);
        send_frame(8'h3C, 0);
        check("midrst_dout", 32'(dout), 32'h3C);
        check("midrst_cnt", 32'(frame_cnt), 32'd1);

        // Good frame, then parity error on the same payload.
        do_reset();
        send_frame(8'hA5, 0);
        check("good_dout", 32'(dout), 32'hA5);
        check("good_cnt", 32'(frame_cnt), 32'd1);
        send_frame(8'hA5, 1);
        check("bad_perr", 32'(parity_err), 32'd1);
        check("bad_cnt", 32'(frame_cnt), 32'd1);

        // Overlapping sync prefix, then a sync-free stream.
        send_bits(7'b1101011, 7);
        send_bits(8'h01, DATA_W);
        send_bits(1, 1);
        check("ovl_dout", 32'(dout), 32'h01);
        check("ovl_perr", 32'(parity_err), 32'd0);
        send_bits(16'h5555, 16);

        // Back-to-back frames, then the same with a mid-payload stall.
        send_frame(8'hFF, 0);
        send_frame(8'h80, 1);
        check("b2b_cnt", 32'(frame_cnt), 32'd4);
        send_frame(8'hFF, 0, 3, 3);
        send_frame(8'h80, 1, 5, 3);
        check("stall_dout", 32'(dout), 32'h80);
        check("stall_cnt", 32'(frame_cnt), 32'd6);

        // Counter wrap on the 2-bit instance.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            d = int'($urandom_range(255));
            send_frame(d, good_par(d));
            check("wrap_seq", 32'(frame_cnt2), 32'(exp_wrap[k]));
        end

        // Randomised frames with noise, stalls, bad parity and rare resets.
        for (int k = 0; k < 60; k++) begin
            int noise;
            noise = int'($urandom_range(5));
            for (int j = 0; j < noise; j++) step(1'($urandom), 1'($urandom_range(3) != 0));
            d = int'($urandom_range(255));
            if ($urandom_range(7) == 0) do_reset();
            send_frame(d, ($urandom_range(3) == 0) ? 1 - good_par(d) : good_par(d),
                       int'($urandom_range(DATA_W + 2)) - 1, int'($urandom_range(3)));
        end
        for (int j = 0; j < 400; j++) step(1'($urandom), 1'($urandom_range(4) != 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Downstream consumer of the `shift_reg` serial output `sout`.
- Hunts the 1-bit stream for a fixed sync pattern, then deserializes a DATA_W-bit word MSB-first, then checks a trailing parity bit.
- Presents the parallel word with a one-cycle valid strobe and an error flag to the next stage (register bank / bus interface).

Parameters:
- SYNC_W, 4, sync pattern width in bits (≥2).
- SYNC, 4'b1011, sync pattern; first-received bit is the MSB.
- DATA_W, 8, payload width in bits (≥2).
- ODD_PAR, 0, 0 = even parity, 1 = odd parity over payload plus parity bit.
- CNT_W, 8, width of the good-frame counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- sin  input  1  serial data in (driven by `shift_reg` sout).
- sin_en  input  1  bit-enable; sin is sampled only on edges where sin_en=1.
- dout  output  DATA_W  last received payload.
- dout_valid  output  1  one-cycle strobe: dout and parity_err updated.
- parity_err  output  1  parity result of the last frame; valid with dout_valid, held after.
- sync_lock  output  1  high while in DATA or PARITY state.
- frame_cnt  output  CNT_W  count of frames with good parity; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=0 at a rising edge), regardless of state:
  - state=HUNT.
  - Sync history, bit counter and data shifter cleared to 0.
  - dout=0, dout_valid=0, parity_err=0, sync_lock=0, frame_cnt=0.
  - Reset mid-frame discards the partial frame; nothing is emitted.
- sin_en=0: state, history, counter and shifter hold; dout_valid forced 0.
- HUNT:
  - Each enabled edge: hist <= {hist[SYNC_W-2:0], sin}.
  - If {hist[SYNC_W-2:0], sin} == SYNC: go to DATA with bit_cnt=0.
  - Overlapping patterns are detected. With SYNC=1011, stream 1011 matches on its 4th bit; stream 1101011 matches on its 7th bit.
- DATA:
  - Each enabled edge: shift <= {shift[DATA_W-2:0], sin}; bit_cnt increments.
  - When bit_cnt == DATA_W-1 on an enabled edge, the last payload bit is captured and the next state is PARITY.
- PARITY:
  - On the next enabled edge, sample the parity bit p.
  - err = (^shift ^ p) != ODD_PAR.
  - Registered at that same edge: dout <= shift, parity_err <= err, dout_valid <= 1, frame_cnt += 1 if !err.
  - Return to HUNT with hist cleared to 0, so payload bits never contribute to the next sync match.
- Latency:
  - dout_valid rises on the edge that samples the parity bit.
  - It is visible for exactly the following clock cycle and is 0 otherwise.
  - Sync-to-valid = SYNC_W + DATA_W + 1 enabled edges after the first sync bit.
- Output hold: dout and parity_err hold between frames. Errored frames still update dout and strobe dout_valid.
- frame_cnt wraps from 2^CNT_W-1 to 0, with no saturation.
- sync_lock = (state != HUNT), driven combinationally from the state register.
- Back-to-back frames: the next sync may start on the enabled edge immediately after the parity edge.
- Illegal state encoding: next state is HUNT.

Decomposition:
- Shared package `serial_rx_pkg` holds:
  - state typedef: HUNT=2'd0, DATA=2'd1, PARITY=2'd2.
  - default constants SYNC_W, SYNC, DATA_W.
  - a parity helper function.
- One sub-module, `sync_window`:
  - SYNC_W-bit history shift register with enable and synchronous clear.
  - Combinational match output.
  - Instantiated once for HUNT.
- FSM, bit counter, data shifter and output registers stay in the top module.

Test Plan (defaults; sin_en=1 unless stated; clock period 20):
- Reset mid-frame: send 1011 plus 3 data bits, pull rst=0 for one edge, release → all outputs 0, no dout_valid, sync_lock=0. Then send 1011, 0x3C, parity 0 → dout=0x3C, parity_err=0, frame_cnt=1.
- Good frame: send 1011, 10100101 (0xA5), parity 0 → exactly one dout_valid cycle with dout=0xA5, parity_err=0, frame_cnt=1. sync_lock is high from the edge after the 4th sync bit through the parity edge.
- Parity error: send 1011, 0xA5, parity 1 → dout_valid pulse, dout=0xA5, parity_err=1, frame_cnt unchanged.
- Overlap and false sync: send 1101011, 0x01, parity 1 → lock on the 7th bit, dout=0x01, parity_err=0. A stream of 0x55 with no sync never asserts sync_lock.
- Back-to-back and stall: two frames (0xFF p0, 0x80 p1) with no gap → two valid pulses, 9+4 edges apart, frame_cnt=2. Repeat with sin_en=0 for 3 cycles mid-payload → the same words result, and valid is delayed by 3 cycles.
- Wrap: CNT_W=2, send 5 good frames → frame_cnt sequence 1, 2, 3, 0, 1.
